lfsr_arb_ctrl: RTL and testbench

LFSR_ARB_CTRL -- requirements
Module: lfsr_arb_ctrl

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/lfsr_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_lfsr_arb_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared definitions for the LFSR burst arbiter/controller.
//   state_t      : controller FSM encoding (IDLE, LOAD, RUN, DONE)
//   LFSR_TAPS    : feedback taps over the internal state q[3:0], where q[i] is stage i
//   GUARD_SEED   : replacement for an all-zero seed (data_out view)
//   rev4()       : maps between the data_out/seed view and the internal stage order
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Feedback into stage 0 is stage 2 xor stage 3 (x^4 + x^3 + 1, maximal length).
    localparam logic [3:0] LFSR_TAPS  = 4'b1100;
    localparam logic [3:0] GUARD_SEED = 4'b0001;

    // Seeds and data_out carry stage 0 in the MSB; the register keeps stage i in bit i.
    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector, bit i = requester i
//   update   : the current grant is being taken; advance the priority pointer
//   gnt      : one-hot combinational grant (zero when req is zero)
// After reset requester 0 wins a tie; afterwards the requester not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // prefer1 high means requester 1 wins the next tie.
    logic prefer1;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prefer1 ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prefer1 <= 1'b0;
        else if (update && (gnt != 2'b00))
            prefer1 <= gnt[0];
    end

endmodule

// File: rtl/lfsr_arb_ctrl.sv
// lfsr_arb_ctrl -- arbitrates two burst requesters and streams a 4-bit LFSR
// sequence to the winner, one beat per data_valid/data_ready handshake.
//   clk, rst          : clock, asynchronous active-low reset
//   req[1:0]          : burst requests
//   seed0/1, len0/1   : per-requester seed and burst length, captured at grant
//                       (length 0 means 2^LEN_W beats)
//   gnt[1:0]          : one-hot grant, held from LOAD through DONE
//   data_out[3:0]     : LFSR state, stage 0 in the MSB
//   data_valid        : high in RUN
//   data_ready        : consumer accepts the current beat
//   done              : one-cycle completion pulse
//   busy              : controller not idle
//   seed_fix          : pulses in LOAD when a zero seed was replaced
// Build option: LFSR_ARB_CTRL_ZERO_GUARD_EN replaces a zero seed with GUARD_SEED;
// without it a zero seed streams zeros and seed_fix is tied low.
import lfsr_pkg::*;

module lfsr_arb_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [3:0]       seed0,
    input  logic [3:0]       seed1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [3:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             done,
    output logic             busy,
    output logic             seed_fix
);

    // One extra counter bit so a length of 0 can load the full 2^LEN_W.
    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

    state_t           state, state_nxt;
    logic [1:0]       arb_gnt;
    logic             arb_upd;
    logic [3:0]       seed_c;
    logic [LEN_W-1:0] len_c;
    logic [LEN_W:0]   cnt;
    logic [3:0]       q;
    logic [3:0]       q_nxt;
    logic [3:0]       load_seed;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb_upd),
        .gnt    (arb_gnt)
    );

    // Stage 0 takes the tap xor, every other stage shifts up by one.
    assign q_nxt = {q[2:0], ^(q & LFSR_TAPS)};

`ifdef LFSR_ARB_CTRL_ZERO_GUARD_EN
    logic seed_zero;
    assign seed_zero = (seed_c == 4'b0000);
    assign load_seed = seed_zero ? GUARD_SEED : seed_c;
    assign seed_fix  = (state == ST_LOAD) && seed_zero;
`else
    assign load_seed = seed_c;
    assign seed_fix  = 1'b0;
`endif

    assign data_out   = rev4(q);
    assign data_valid = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arb_upd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    arb_upd   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                if (data_ready && (cnt == CNT_ONE))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= 2'b00;
            seed_c <= 4'b0000;
            len_c  <= '0;
            cnt    <= '0;
            q      <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt    <= arb_gnt;
                        seed_c <= arb_gnt[1] ? seed1 : seed0;
                        len_c  <= arb_gnt[1] ? len1  : len0;
                    end
                end
                ST_LOAD: begin
                    q   <= rev4(load_seed);
                    cnt <= (len_c == '0) ? CNT_FULL : {1'b0, len_c};
                end
                ST_RUN: begin
                    if (data_ready) begin
                        q   <= q_nxt;
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DONE: gnt <= 2'b00;
                default: gnt <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
module tb_lfsr_arb_ctrl;

    localparam int LEN_W = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [3:0]       seed0, seed1;
    logic [LEN_W-1:0] len0, len1;
    logic [1:0]       gnt;
    logic [3:0]       data_out;
    logic             data_valid;
    logic             data_ready;
    logic             done;
    logic             busy;
    logic             seed_fix;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];
    logic [3:0] last_obs;
    logic [3:0] start_v;
    logic       exp_fix;

    lfsr_arb_ctrl #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .seed0      (seed0),
        .seed1      (seed1),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .done       (done),
        .busy       (busy),
        .seed_fix   (seed_fix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference next value in the data_out view (stage 0 in the MSB):
    // new stage0 = stage2 ^ stage3 = bit1 ^ bit0, the rest shift toward bit 0.
    function automatic logic [3:0] model_next(input logic [3:0] d);
        return {d[1] ^ d[0], d[3:1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [3:0] start, input int n);
        logic [3:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back(v);
            v = model_next(v);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_gnt"},   gnt,        0);
        chk({tag, "_data"},  data_out,   0);
        chk({tag, "_valid"}, data_valid, 0);
        chk({tag, "_done"},  done,       0);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_fix"},   seed_fix,   0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_idle_zero(tag);
        step();
        step();
        rst = 1'b1;
    endtask

    // Called at an IDLE sample point with req already driven. Checks LOAD,
    // optionally drops req and scrambles the inputs, then checks first data_valid.
    task automatic launch(input string tag, input logic [1:0] expg,
                          input bit drop, input logic fix);
        step();
        chk({tag, "_load_gnt"},   gnt,        expg);
        chk({tag, "_load_busy"},  busy,       1);
        chk({tag, "_load_valid"}, data_valid, 0);
        chk({tag, "_load_fix"},   seed_fix,   fix);
        if (drop) begin
            req   = 2'b00;
            seed0 = ~seed0;
            seed1 = ~seed1;
            len0  = len0 + 4'd5;
            len1  = len1 + 4'd5;
        end
        step();
        chk({tag, "_latency"}, data_valid, 1);
    endtask

    task automatic drain(input string tag, input logic [1:0] expg, input logic [3:0] rdy_pat,
                         input int nbeats, output logic [3:0] last);
        int beats;
        bit seen;
        bit held;
        logic [3:0] hv;
        logic [3:0] e;
        beats = 0;
        seen  = 0;
        held  = 0;
        hv    = '0;
        last  = '0;
        for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
            data_ready = rdy_pat[cyc % 4];
            if (data_valid) begin
                chk({tag, "_gnt"}, gnt, expg);
                if (held) chk({tag, "_hold"}, data_out, hv);
                held = 0;
                if (data_ready) begin
                    if (sb.size() > 0) e = sb.pop_front();
                    else e = 4'bxxxx;
                    chk({tag, "_data"}, data_out, e);
                    last = data_out;
                    beats++;
                end else begin
                    held = 1;
                    hv   = data_out;
                end
            end
            if (done) begin
                seen = 1;
                chk({tag, "_done_gnt"},   gnt,        expg);
                chk({tag, "_done_valid"}, data_valid, 0);
            end
            step();
        end
        data_ready = 1'b0;
        chk({tag, "_done_seen"}, seen,      1);
        chk({tag, "_beats"},     beats,     nbeats);
        chk({tag, "_sb_empty"},  sb.size(), 0);
        chk({tag, "_post_done"}, done,      0);
        chk({tag, "_post_gnt"},  gnt,       0);
        chk({tag, "_post_busy"}, busy,      0);
    endtask

    initial begin
        rst        = 1'b0;
        req        = 2'b00;
        seed0      = 4'b0000;
        seed1      = 4'b0000;
        len0       = '0;
        len1       = '0;
        data_ready = 1'b0;

        do_reset("rst0");

        // S1: single requester, full-rate consumer, inputs disturbed after capture.
        seed0 = 4'b1000; len0 = 4; req = 2'b01;
        push_seq(4'b1000, 4);
        launch("s1", 2'b01, 1, 1'b0);
        drain("s1", 2'b01, 4'b1111, 4, last_obs);

        // S2: both requesting continuously -> 01, 10, 01 after a fresh reset.
        do_reset("rst1");
        seed0 = 4'b0011; len0 = 2;
        seed1 = 4'b0110; len1 = 3;
        req = 2'b11;
        push_seq(4'b0011, 2);
        launch("s2a", 2'b01, 0, 1'b0);
        drain("s2a", 2'b01, 4'b1111, 2, last_obs);
        push_seq(4'b0110, 3);
        launch("s2b", 2'b10, 0, 1'b0);
        drain("s2b", 2'b10, 4'b1111, 3, last_obs);
        push_seq(4'b0011, 2);
        launch("s2c", 2'b01, 1, 1'b0);
        drain("s2c", 2'b01, 4'b1111, 2, last_obs);

        // S3: back-pressure pattern 1,0,0,1.
        seed0 = 4'b1001; len0 = 4; req = 2'b01;
        push_seq(4'b1001, 4);
        launch("s3", 2'b01, 1, 1'b0);
        drain("s3", 2'b01, 4'b1001, 4, last_obs);

        // S4: zero seed.
`ifdef LFSR_ARB_CTRL_ZERO_GUARD_EN
        start_v = 4'b0001;
        exp_fix = 1'b1;
`else
        start_v = 4'b0000;
        exp_fix = 1'b0;
`endif
        seed0 = 4'b0000; len0 = 3; req = 2'b01;
        push_seq(start_v, 3);
        launch("s4", 2'b01, 1, exp_fix);
        drain("s4", 2'b01, 4'b1111, 3, last_obs);

        // S5: length 0 gives 16 beats; beat 16 wraps back to the seed.
        seed0 = 4'b0001; len0 = 0; req = 2'b01;
        push_seq(4'b0001, 16);
        launch("s5", 2'b01, 1, 1'b0);
        drain("s5", 2'b01, 4'b1111, 16, last_obs);
        chk("s5_wrap", last_obs, 4'b0001);

        // S6: reset in the middle of RUN.
        seed0 = 4'b1100; len0 = 8; req = 2'b01;
        push_seq(4'b1100, 8);
        launch("s6", 2'b01, 1, 1'b0);
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s6_pre_data", data_out, sb.pop_front());
            step();
        end
        #2;
        rst = 1'b0;
        #1;
        chk_idle_zero("s6_async");
        data_ready = 1'b0;
        sb.delete();
        step();
        chk("s6_nodone_a", done, 0);
        step();
        chk("s6_nodone_b", done, 0);
        seed0 = 4'b0101; len0 = 2;
        seed1 = 4'b1110; len1 = 2;
        rst = 1'b1;
        req = 2'b11;
        push_seq(4'b0101, 2);
        launch("s6r", 2'b01, 1, 1'b0);
        drain("s6r", 2'b01, 4'b1111, 2, last_obs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
